lfsr13: RTL and testbench

- Free-running 13-bit maximal-length Fibonacci LFSR pseudo-random sequence generator.
- Steps once per clock from a fixed non-zero seed.
- Flags completion of each full period (8191 states) with a one-cycle `lfsr_done` pulse.
- Used as a random-value source (e.g. private-exponent generation) feeding the key-exchange datapath.

---
 rtl/lfsr_pkg.sv | 12 +
 rtl/lfsr13_step.sv | 29 ++
 rtl/lfsr13.sv | 49 ++++
 tb/tb_lfsr13.sv | 128 ++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and state type for the 13-bit maximal-length LFSR,
// also used by consumers that check the generated sequence.
package lfsr_pkg;

  localparam int          LFSR_WIDTH = 13;
  localparam logic [12:0] LFSR_SEED  = 13'h0001;
  // x^13 + x^4 + x^3 + x + 1 expressed as taps on bits 12, 3, 2, 0
  localparam logic [12:0] LFSR_TAPS  = 13'h100D;

  typedef logic [LFSR_WIDTH-1:0] lfsr_t;

endpackage

// File: rtl/lfsr13_step.sv
// Combinational next-state function of the Fibonacci LFSR: tap XOR,
// left shift with feedback into bit 0, and recovery from the all-zero state.
module lfsr13_step
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  logic fb;

  always_comb begin
    fb   = ^(cur & TAPS);
    nxt  = {cur[WIDTH-2:0], fb};
    wrap = 1'b0;
    // Zero is a lock-up state; reload the seed without flagging a wrap.
    if (cur == '0) begin
      nxt = SEED;
    end else begin
      wrap = (nxt == SEED);
    end
  end

endmodule

// File: rtl/lfsr13.sv
// Free-running 13-bit LFSR; lfsr_done pulses for the one cycle in which the
// state has just returned to the seed after a full 8191-state period.
module lfsr13
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic             clk,
  input  logic             rst,
  output logic             lfsr_done,
  output logic [WIDTH-1:0] lfsr
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic             done_q;
  logic             done_d;
  logic             wrap;

  lfsr13_step #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_step (
    .cur  (lfsr_q),
    .nxt  (lfsr_d),
    .wrap (wrap)
  );

  always_comb begin
    done_d = wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
      done_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= done_d;
    end
  end

  assign lfsr      = lfsr_q;
  assign lfsr_done = done_q;

endmodule

// File: tb/tb_lfsr13.sv
// Self-checking bench for lfsr13: reference sequence from the polynomial's
// parity rule, period bookkeeping by edge count, uniqueness via a seen-table.
module tb_lfsr13;
  import lfsr_pkg::*;

  localparam int PERIOD = 8191;

  logic        clk;
  logic        rst;
  logic        lfsr_done;
  logic [12:0] lfsr;

  int checks   = 0;
  int failures = 0;

  lfsr13 dut (
    .clk       (clk),
    .rst       (rst),
    .lfsr_done (lfsr_done),
    .lfsr      (lfsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the new bit is the parity of the tapped bits (mod-2 sum of the
  // polynomial terms); zero is replaced by the seed.
  function automatic logic [12:0] ref_next(input logic [12:0] s);
    int ones;
    if (s == 13'd0) return LFSR_SEED;
    ones = 0;
    for (int b = 0; b < 13; b++) if (LFSR_TAPS[b] && s[b]) ones++;
    return (13'((int'(s) * 2) % 8192)) | 13'(ones % 2);
  endfunction

  logic [12:0] model;
  bit          seen [8192];
  int          pulses;
  int          edge_n;
  logic [12:0] first_vals [5];

  initial begin
    first_vals[0] = 13'h0003; first_vals[1] = 13'h0007; first_vals[2] = 13'h000E;
    first_vals[3] = 13'h001C; first_vals[4] = 13'h0038;

    // Reset held with clock running.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("reset_lfsr", 32'(lfsr), 32'h1);
      check_eq("reset_done", 32'(lfsr_done), 32'h0);
    end

    // Release and run two full periods.
    rst = 1'b1;
    model = LFSR_SEED;
    pulses = 0;
    for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
    for (int n = 1; n <= 2 * PERIOD; n++) begin
      @(posedge clk); #1;
      model = ref_next(model);
      if (n <= 5) check_eq($sformatf("first_step%0d", n), 32'(lfsr), 32'(first_vals[n-1]));
      check_eq($sformatf("seq_lfsr@%0d", n), 32'(lfsr), 32'(model));
      check_eq($sformatf("seq_done@%0d", n), 32'(lfsr_done), 32'((n % PERIOD) == 0));
      if (lfsr_done) pulses++;
      if (n <= PERIOD) begin
        check_eq($sformatf("nonzero@%0d", n), 32'(lfsr != 13'd0), 32'h1);
        check_eq($sformatf("unique@%0d", n), 32'(seen[lfsr]), 32'h0);
        seen[lfsr] = 1'b1;
      end
    end
    check_eq("pulse_count", 32'(pulses), 32'd2);

    // Mid-sequence reset: asynchronous assertion between edges at cycle 5000.
    @(negedge clk);
    model = LFSR_SEED;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk);
      model = ref_next(model);
    end
    #1 check_eq("pre_reset_lfsr", 32'(lfsr), 32'(model));
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_lfsr", 32'(lfsr), 32'h1);
    check_eq("async_rst_done", 32'(lfsr_done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("hold_rst_lfsr", 32'(lfsr), 32'h1);
      check_eq("hold_rst_done", 32'(lfsr_done), 32'h0);
    end
    rst = 1'b1;
    model = LFSR_SEED;
    pulses = 0;
    for (int n = 1; n <= PERIOD + 5; n++) begin
      @(posedge clk); #1;
      model = ref_next(model);
      check_eq($sformatf("rel2_lfsr@%0d", n), 32'(lfsr), 32'(model));
      check_eq($sformatf("rel2_done@%0d", n), 32'(lfsr_done), 32'(n == PERIOD));
      if (lfsr_done) pulses++;
    end
    check_eq("rel2_pulse_count", 32'(pulses), 32'd1);

    // Lock-up guard: deposit zero into the state register.
    @(negedge clk);
    dut.lfsr_q = 13'd0;
    #1 check_eq("deposit_zero", 32'(lfsr), 32'h0);
    model = 13'd0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      model = ref_next(model);
      check_eq($sformatf("lockup_lfsr@%0d", n), 32'(lfsr), 32'(model));
      check_eq($sformatf("lockup_done@%0d", n), 32'(lfsr_done), 32'h0);
    end
    check_eq("lockup_after3", 32'(lfsr), 32'h000E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
